// File: rtl/sevenseg_pkg.sv
// Shared definitions for the two-digit multiplexed seven-segment bus.
// Used by both the display driver and the capture monitor.
//   - SEG_CODES : active-low segment patterns (bit order g..a) for 0..F
//   - SEG_ERR   : pattern the driver emits for an unrepresentable value
//   - AN_*      : active-low anode selects
//   - frame_state_t : frame reassembly state of the capture side
package sevenseg_pkg;

    localparam logic [6:0] SEG_CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_ERR = 7'b1010101;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        GOT0  = 2'd1,
        GOT1  = 2'd2
    } frame_state_t;

endpackage

// File: rtl/sevenseg_capture_if.sv
// Bundle between the snooped display bus and the capture monitor.
//   an, seg : active-low anode / segment lines (driven by the display side)
//   num     : last committed {digit1, digit0}
//   valid   : one-cycle pulse when num updates
//   idle    : bus blank for at least the idle timeout
//   err     : one-cycle pulse on an accepted illegal pattern
//   state   : frame FSM state, exposed for debug/checkers
// Handshake: valid and err are single-cycle, unacknowledged pulses; there is
// no backpressure, the consumer must sample them on the cycle they are high.
interface sevenseg_capture_if;
    import sevenseg_pkg::*;

    logic [3:0]   an;
    logic [6:0]   seg;
    logic [7:0]   num;
    logic         valid;
    logic         idle;
    logic         err;
    frame_state_t state;

    modport master (
        output an, seg,
        input  num, valid, idle, err, state
    );

    modport slave (
        input  an, seg,
        output num, valid, idle, err, state
    );

endinterface

// File: rtl/sevenseg_capture_seg_decode.sv
// Combinational inverse of the driver's segment table.
//   seg    : active-low segment pattern, g..a
//   legal  : pattern is one of the 16 hex codes
//   nibble : decoded value (0 when not legal)
module seg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODES[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Snooping receiver for the two-digit multiplexed seven-segment bus.
// Registers {an,seg}, accepts a pattern once it has held for STABLE_CYCLES
// samples, decodes it and reassembles {digit1,digit0} into num.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave side of sevenseg_capture_if (an/seg in, num/valid/idle/err/state out)
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int IDLE_TIMEOUT  = 600000
) (
    input  logic              CLK,
    input  logic              RST,
    sevenseg_capture_if.slave bus
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

    logic [10:0]  din, in_q;
    logic [3:0]   an_q;
    logic [SW-1:0] stab_cnt;
    logic          run_done;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          idle_rise;
    logic          accept;
    logic          legal;
    logic [3:0]    nibble;
    logic          cap_d0, cap_d1, acc_err, commit;
    logic [7:0]    num_d;
    frame_state_t  state_q, state_d;
    logic [7:0]    num_q;
    logic [3:0]    d0_q, d1_q;
    logic          valid_q, err_q;

    assign din  = {bus.an, bus.seg};
    assign an_q = in_q[10:7];

    seg_decode u_dec (
        .seg    (in_q[6:0]),
        .legal  (legal),
        .nibble (nibble)
    );

    // One accept per stable run: run_done blocks repeats until the input changes.
    assign accept = (stab_cnt == STAB_LAST) && !run_done;

    // The idle count follows the sample being registered this edge, so idle
    // rises on the edge that registers the last required blank sample.
    always_comb begin
        idle_nxt = '0;
        if (din[10:7] == AN_OFF) begin
            idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IW'(1);
        end
    end

    assign idle_rise = (idle_nxt == IDLE_MAX) && (idle_cnt != IDLE_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_q     <= {AN_OFF, SEG_OFF};
            stab_cnt <= '0;
            run_done <= 1'b0;
            idle_cnt <= '0;
        end else begin
            in_q     <= din;
            idle_cnt <= idle_nxt;
            if (din == in_q) begin
                if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + SW'(1);
                if (accept) run_done <= 1'b1;
            end else begin
                stab_cnt <= '0;
                run_done <= 1'b0;
            end
        end
    end

    // Classify the accepted pattern. A blank bus is neither captured nor an error.
    always_comb begin
        cap_d0  = accept && (an_q == AN_D0) && legal;
        cap_d1  = accept && (an_q == AN_D1) && legal;
        acc_err = accept && (((an_q != AN_D0) && (an_q != AN_D1) && (an_q != AN_OFF)) ||
                             (((an_q == AN_D0) || (an_q == AN_D1)) && !legal));
    end

    // Frame FSM: state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Frame FSM: next state
    always_comb begin
        state_d = state_q;
        if (idle_rise) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (cap_d0)      state_d = GOT0;
                    else if (cap_d1) state_d = GOT1;
                end
                GOT0:    if (cap_d1) state_d = EMPTY;
                GOT1:    if (cap_d0) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Frame FSM: outputs. A frame completes when the opposite digit arrives.
    always_comb begin
        commit = !idle_rise && (((state_q == GOT0) && cap_d1) ||
                                ((state_q == GOT1) && cap_d0));
        num_d  = {cap_d1 ? nibble : d1_q, cap_d0 ? nibble : d0_q};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            num_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= commit;
            err_q   <= acc_err;
            if (cap_d0) d0_q <= nibble;
            if (cap_d1) d1_q <= nibble;
            if (commit) num_q <= num_d;
        end
    end

    assign bus.num   = num_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.idle  = (idle_cnt == IDLE_MAX);
    assign bus.state = state_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
module tb_sevenseg_capture;
    import sevenseg_pkg::*;

    localparam int S = 4;
    localparam int T = 20;

    // Reference segment table, written out independently of the design.
    localparam logic [6:0] TB_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic CLK = 1'b0;
    logic RST = 1'b1;

    sevenseg_capture_if bus ();

    sevenseg_capture #(
        .STABLE_CYCLES (S),
        .IDLE_TIMEOUT  (T)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int last_valid_cyc = -1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A pattern is acted on once it has been seen for S consecutive samples
    // (the reset value of the sampler counts as one sample of the blank bus).
    // Idle means the last T samples were all blank.
    logic [10:0] cur_pat = 11'h7FF;
    int          run_len = 1;
    int          blank_run = 0;
    bit          have0 = 0, have1 = 0;
    logic [3:0]  m_d0 = 0, m_d1 = 0;
    logic [7:0]  e_num = 0;
    bit          e_valid = 0, e_err = 0, e_idle = 0;

    function automatic void tb_decode(input logic [6:0] s, output bit ok, output logic [3:0] n);
        ok = 0;
        n  = 0;
        for (int i = 0; i < 16; i++) begin
            if (TB_SEG[i] == s) begin
                ok = 1;
                n  = 4'(i);
            end
        end
    endfunction

    task automatic model_reset();
        cur_pat = 11'h7FF; run_len = 1; blank_run = 0;
        have0 = 0; have1 = 0; m_d0 = 0; m_d1 = 0;
        e_num = 0; e_valid = 0; e_err = 0; e_idle = 0;
    endtask

    task automatic model_step(input logic [10:0] smp);
        bit         ok;
        logic [3:0] n;
        logic [3:0] a;
        e_valid = 0;
        e_err   = 0;
        if (run_len == S) begin
            a = cur_pat[10:7];
            tb_decode(cur_pat[6:0], ok, n);
            if (a == 4'b1111) begin
            end else if ((a == 4'b1110 || a == 4'b1101) && ok) begin
                if (a == 4'b1110) begin
                    if (have1) begin
                        e_num = {m_d1, n}; e_valid = 1; have0 = 0; have1 = 0;
                    end else begin
                        m_d0 = n; have0 = 1;
                    end
                end else begin
                    if (have0) begin
                        e_num = {n, m_d0}; e_valid = 1; have0 = 0; have1 = 0;
                    end else begin
                        m_d1 = n; have1 = 1;
                    end
                end
            end else begin
                e_err = 1;
            end
        end
        if (smp == cur_pat) begin
            if (run_len < 1000) run_len++;
        end else begin
            cur_pat = smp;
            run_len = 1;
        end
        if (smp[10:7] == 4'b1111) begin
            if (blank_run < T) begin
                blank_run++;
                if (blank_run == T) begin
                    have0 = 0; have1 = 0;
                end
            end
        end else begin
            blank_run = 0;
        end
        e_idle = (blank_run == T);
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) model_reset();
        else     model_step({bus.an, bus.seg});
    end

    function automatic frame_state_t exp_state();
        if (have0)      return GOT0;
        else if (have1) return GOT1;
        else            return EMPTY;
    endfunction

    // ---------------- scoreboard: compare every cycle ----------------
    always @(negedge CLK) begin
        check("num",   32'(bus.num),   32'(e_num));
        check("valid", 32'(bus.valid), 32'(e_valid));
        check("err",   32'(bus.err),   32'(e_err));
        check("idle",  32'(bus.idle),  32'(e_idle));
        check("state", 32'(bus.state), 32'(exp_state()));
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (bus.err === 1'b1) err_cnt++;
    end

    // ---------------- driver ----------------
    // Inputs change 2 time units after a rising edge, then hold for n edges.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(posedge CLK);
        #2;
    endtask

    int base_v, base_e, t0;

    initial begin
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        RST     = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        check("reset_num",   32'(bus.num), 32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_state", 32'(bus.state), 32'(EMPTY));
        RST = 1'b0;

        // 1: digit0=5 then digit1=1 -> 0x15, valid 4 edges after the change
        base_v = valid_cnt; base_e = err_cnt;
        hold(4'b1110, 7'b0010010, 10);
        t0 = cyc;
        hold(4'b1101, 7'b1111001, 10);
        check("t1_num", 32'(bus.num), 32'h15);
        check("t1_valid_count", 32'(valid_cnt - base_v), 32'd1);
        check("t1_latency", 32'(last_valid_cyc - (t0 + 1)), 32'd4);
        check("t1_no_err", 32'(err_cnt - base_e), 32'd0);

        // 2: short glitch of '8' ignored, '0' accepted, then '6' -> 0x60
        base_e = err_cnt;
        hold(4'b1110, 7'b0000000, 3);
        hold(4'b1110, 7'b1000000, 8);
        check("t2_state_got0", 32'(bus.state), 32'(GOT0));
        hold(4'b1101, 7'b0000010, 8);
        check("t2_num", 32'(bus.num), 32'h60);
        check("t2_no_err", 32'(err_cnt - base_e), 32'd0);

        // 3: illegal segment pattern -> one err, nothing captured
        base_e = err_cnt; base_v = valid_cnt;
        hold(4'b1101, 7'b1010101, 8);
        check("t3_err_once", 32'(err_cnt - base_e), 32'd1);
        check("t3_num_kept", 32'(bus.num), 32'h60);
        check("t3_state_kept", 32'(bus.state), 32'(EMPTY));
        hold(4'b1110, 7'b0100100, 6);
        hold(4'b1101, 7'b0010000, 6);
        check("t3_num_after", 32'(bus.num), 32'h92);
        check("t3_valid_once", 32'(valid_cnt - base_v), 32'd1);

        // 4: illegal anode value -> one err, no capture
        base_e = err_cnt; base_v = valid_cnt;
        hold(4'b1100, 7'b1000000, 6);
        check("t4_err_once", 32'(err_cnt - base_e), 32'd1);
        check("t4_no_valid", 32'(valid_cnt - base_v), 32'd0);
        check("t4_state", 32'(bus.state), 32'(EMPTY));

        // 5: partial frame dropped by idle, then 0xA3
        hold(4'b1110, 7'b1111000, 6);
        check("t5_got0", 32'(bus.state), 32'(GOT0));
        hold(4'b1111, 7'b1111111, 19);
        check("t5_idle_low_19", 32'(bus.idle), 32'd0);
        hold(4'b1111, 7'b1111111, 1);
        check("t5_idle_high_20", 32'(bus.idle), 32'd1);
        check("t5_dropped", 32'(bus.state), 32'(EMPTY));
        check("t5_num_held", 32'(bus.num), 32'h92);
        base_v = valid_cnt;
        hold(4'b1101, 7'b0001000, 1);
        check("t5_idle_fall", 32'(bus.idle), 32'd0);
        hold(4'b1101, 7'b0001000, 5);
        hold(4'b1110, 7'b0110000, 6);
        check("t5_num", 32'(bus.num), 32'hA3);
        check("t5_valid_once", 32'(valid_cnt - base_v), 32'd1);

        // 6: asynchronous reset mid-frame
        hold(4'b1110, 7'b0010010, 6);
        #1 RST = 1'b1;
        #1;
        check("t6_async_num", 32'(bus.num), 32'h0);
        check("t6_async_valid", 32'(bus.valid), 32'h0);
        check("t6_async_err", 32'(bus.err), 32'h0);
        check("t6_async_idle", 32'(bus.idle), 32'h0);
        check("t6_async_state", 32'(bus.state), 32'(EMPTY));
        @(posedge CLK);
        #2 RST = 1'b0;
        base_v = valid_cnt;
        hold(4'b1101, 7'b1111001, 8);
        check("t6_no_valid_half", 32'(valid_cnt - base_v), 32'd0);
        hold(4'b1110, 7'b0010010, 8);
        check("t6_new_frame", 32'(bus.num), 32'h15);
        check("t6_valid_once", 32'(valid_cnt - base_v), 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            int r, r2;
            logic [3:0] a;
            logic [6:0] s;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                hold(4'b1111, 7'b1111111, $urandom_range(15, 25));
            end else begin
                r2 = $urandom_range(0, 99);
                if (r2 < 40)      a = 4'b1110;
                else if (r2 < 80) a = 4'b1101;
                else if (r2 < 90) a = 4'b1111;
                else              a = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 99) < 85) s = TB_SEG[$urandom_range(0, 15)];
                else                            s = 7'($urandom_range(0, 127));
                hold(a, s, $urandom_range(1, 7));
            end
        end
        hold(4'b1111, 7'b1111111, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive-side counterpart of the board's two-digit multiplexed seven-segment driver.
- Snoops the active-low anode/segment bus, filters multiplex glitches, and decodes each segment pattern back to a hex nibble.
- Reassembles the displayed 8-bit value and reports idle (blanked) and illegal-pattern conditions.
- Used as a self-check monitor in board bring-up and as a loopback receiver in system tests.

Parameters:
- STABLE_CYCLES, 4: consecutive sampled cycles an {an,seg} pattern must hold before it is accepted (min 2).
- IDLE_TIMEOUT, 600000: consecutive blank cycles (an=1111) before idle asserts. The bench uses 20.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- an  in  4  anode enables, active-low (1110=digit0, 1101=digit1, 1111=blank).
- seg  in  7  segment lines, active-low, bit order g..a.
- num  out  8  last committed value {digit1, digit0}.
- valid  out  1  one-cycle pulse when num is updated.
- idle  out  1  high while the bus has been blank for at least IDLE_TIMEOUT cycles.
- err  out  1  one-cycle pulse on acceptance of an illegal anode or segment pattern.

Behaviour:
- Reset: asynchronous and active-high, per the decided interface. While RST=1:
  - num=0, valid=0, idle=0, err=0.
  - FSM=EMPTY; all counters and registers=0; input register=1111_1111111.
  - Reset mid-frame discards the partial digit with no valid pulse.
- Input stage: {an,seg} registered once every cycle.
- Stability counter:
  - Counts consecutive edges on which the registered value equals its previous value; resets to 0 on any change.
  - Accept fires exactly once per stable run, when the count reaches STABLE_CYCLES-1. A per-run flag prevents re-acceptance.
  - Glitches shorter than STABLE_CYCLES samples are ignored silently.
- Segment decode: inverse of the driver's encoding table.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110
  - Any other pattern, including 1010101, is illegal.
- On accept:
  - an=1110 with legal seg: capture d0.
  - an=1101 with legal seg: capture d1.
  - an=1111: no capture and no err.
  - Any other an value, or an illegal seg with an=1110/1101: err=1 for one cycle; nothing captured; FSM unchanged.
- Frame FSM:
  - States: EMPTY, GOT0, GOT1.
  - EMPTY: capture d0 goes to GOT0; capture d1 goes to GOT1.
  - GOT0: capture d0 overwrites d0 and stays. Capture d1 commits num<={d1,d0}, pulses valid, and goes to EMPTY.
  - GOT1: symmetric to GOT0.
- Latency: if a pattern is stable at the input before edge n, capture/commit (num, valid, err) is visible after edge n+STABLE_CYCLES. valid is high for exactly that one cycle.
- Idle counter:
  - Increments while the registered an=1111 and saturates at IDLE_TIMEOUT; clears on any non-blank an.
  - idle = (count == IDLE_TIMEOUT).
  - On the edge idle rises, the FSM is forced to EMPTY. num holds its value.
  - Idle and accept can never coincide, since accept of a digit requires a non-blank an.
- Widths: stability counter is $clog2(STABLE_CYCLES+1) bits; idle counter is $clog2(IDLE_TIMEOUT+1) bits. No wrap: both counters saturate.

Decomposition:
- Shared package sevenseg_pkg, also used by the driver:
  - the 16 segment codes and SEG_ERR=1010101;
  - AN_D0=1110, AN_D1=1101, AN_OFF=1111;
  - frame FSM state encoding.
- One combinational sub-module, seg_decode: 7-bit seg in → {legal, nibble[3:0]} out.

Test Plan:
1. Reset; an=1110/seg=0010010 for 10 cycles, then an=1101/seg=1111001 for 10 cycles → num=8'h15; single valid pulse 4 edges after the digit1 change; err never high.
2. an=1110/seg=0000000 for 3 cycles, then seg=1000000 held → only digit 0 accepted; then an=1101/seg=0000010 → num=8'h60; no err.
3. an=1101/seg=1010101 held 8 cycles → exactly one err pulse; num and FSM unchanged; then a legal d0/d1 pair still commits normally.
4. an=1100 held 6 cycles → one err pulse, no capture.
5. IDLE_TIMEOUT=20:
   - Capture d0=7, then an=1111 for 20 cycles → idle rises at the 20th blank edge and the partial frame is discarded.
   - Then d1=A, d0=3 → num=8'hA3 with one valid pulse; idle falls on the first non-blank edge.
6. Assert RST between the edges after digit0 is captured → all outputs 0 immediately with no clock edge; after release, a full new frame is required before valid.
